ecg_result_uart_tx: RTL and testbench
=====================================

# ecg_result_uart_tx

Output stage for the ECG FIR low-pass filter. It tracks which filter outputs are valid by delaying the input-sample strobe through a delay line matched to the filter latency. Each valid result is saturated to 16 bits, queued in a small FIFO and transmitted over an 8N1 UART as a 3-byte frame. It sits directly after the filter and is the transmit end of the board's ECG result link.

## Interface

Parameters:
- IN_WIDTH, 38: width of the filter result `y_in` (signed, already rescaled to sample units).
- OUT_WIDTH, 16: width of the transmitted sample (signed). Fixed at 16 because of the 2-byte payload.
- LATENCY, 9: cycles from a sample entering the filter to its result appearing on `y_in`.
- FIFO_DEPTH, 16: result FIFO depth. Must be a power of 2 and at least 2.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- sample_valid, in, 1: high for one cycle when a new sample enters the filter.
- y_in, in, IN_WIDTH: signed filter output.
- tx, out, 1: UART serial line; idles high.
- busy, out, 1: high while a frame is in flight.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: number of FIFO entries.
- overflow_cnt, out, 8: count of dropped results; saturates at 255.

## Operation

- **Valid tracking:** `sample_valid` feeds a LATENCY-deep shift register. When the tap is high, `y_in` is captured on that edge.
- **Saturation:**
  - `y_in` > 32767 becomes 0x7FFF.
  - `y_in` < -32768 becomes 0x8000.
  - Otherwise `y_in[15:0]` is used unchanged.
- **FIFO write:** the saturated word is pushed.
  - A push is accepted if `fifo_level` < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow_cnt` increments, saturating at 255.
- **FIFO read:** the transmitter pops one word in IDLE when the FIFO is non-empty.
- **Frame format:** 0xA5, then sample[15:8], then sample[7:0].
- **Byte format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- **Transmitter state machine:**
  - IDLE: `tx`=1. Go to START on pop, latching the word and setting byte_idx=0.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: `tx`=current byte[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - If byte_idx<2: increment byte_idx and go to START.
    - Otherwise go to IDLE.
- **Gaps:** there is no gap between the three bytes of one frame.
- **Back-to-back frames:** a frame may start the cycle after STOP ends if the FIFO is non-empty. In that case IDLE lasts exactly one cycle.
- **busy:** high in START, DATA and STOP.

## Timing

- **Reset values:**
  - `tx`=1, `busy`=0, `fifo_level`=0, `overflow_cnt`=0.
  - Delay line, FIFO pointers, state (IDLE), bit counter and baud counter are all cleared.
- **Reset mid-frame:** the frame is abandoned. `tx` goes high asynchronously, and queued data and in-flight valids are discarded.
- **Capture timing:** for `sample_valid` high in cycle t, `y_in` is sampled at the rising edge ending cycle t+LATENCY.
- **FIFO timing:** the entry is visible (`fifo_level` incremented) in cycle t+LATENCY+1.
- **First start bit:** if the transmitter is idle and the FIFO was empty, the word is popped at the edge ending cycle t+LATENCY+1, and `tx`=0 from cycle t+LATENCY+2.
- **Frame length:** exactly 30×CLKS_PER_BIT cycles.
- **Line changes:** `tx` changes only on baud-counter wrap or state entry and is glitch-free (registered output).
- **Simultaneous push and pop:** allowed. `fifo_level` is unchanged; at FIFO_DEPTH the new word is accepted.
- **Pointer wrap:** read and write pointers wrap modulo FIFO_DEPTH.
- **Full/empty:** distinguished by `fifo_level`.
- **Back-to-back valids:** consecutive-cycle valids are each captured independently. Throughput is limited only by FIFO depth.

## Test plan

- **Reset values:** assert `rst` mid-stream → `tx`=1, `busy`=0, `fifo_level`=0 and `overflow_cnt`=0 in the same cycle. No further bytes are sent after release.
- **Single sample, CLKS_PER_BIT=4, LATENCY=9:**
  - Stimulus: `sample_valid` at cycle 0, `y_in`=0x1234 at cycle 9.
  - Required: `tx` falls at cycle 11; decoded bytes are A5 12 34; `busy` falls at cycle 131.
- **Saturation:** `y_in`=40000 → bytes A5 7F FF; `y_in`=-40000 → A5 80 00; `y_in`=-1 → A5 FF FF.
- **Overflow, FIFO_DEPTH=4:**
  - Stimulus: 10 valids on consecutive cycles.
  - Required: 5 frames are sent (1 popped immediately plus 4 queued) and `overflow_cnt`=5.
- **Back-to-back frames:** 3 queued samples → 3 frames separated by exactly one IDLE cycle, with bytes in push order.
- **Counter saturation:** 300 drops with `tx` stalled behind a full FIFO → `overflow_cnt` holds at 255.

Source files
------------

// File: rtl/ecg_result_uart_tx.sv
// ECG FIR result output stage: valid tracking, 16-bit saturation, result FIFO
// and 8N1 UART transmitter sending 3-byte frames (0xA5, sample MSB, sample LSB).
module ecg_result_uart_tx #(
   parameter int unsigned IN_WIDTH     = 38,
   parameter int unsigned OUT_WIDTH    = 16,
   parameter int unsigned LATENCY      = 9,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample_valid,
   input  logic [IN_WIDTH-1:0]           y_in,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    overflow_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Valid delay line matched to the filter latency
   logic [LATENCY-1:0] vld_q;
   logic               tap_c;

   generate
      if (LATENCY == 1) begin : g_dl1
         always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_q <= '0;
            else     vld_q <= sample_valid;
         end
      end else begin : g_dln
         always_ff @(posedge clk or posedge rst) begin
            if (rst) vld_q <= '0;
            else     vld_q <= {vld_q[LATENCY-2:0], sample_valid};
         end
      end
   endgenerate

   assign tap_c = vld_q[LATENCY-1];

   // Saturate the wide filter result to the transmitted sample width
   logic signed [IN_WIDTH-1:0]  y_s;
   logic        [OUT_WIDTH-1:0] sat_word_c;

   assign y_s = $signed(y_in);

   always_comb begin
      sat_word_c = y_in[OUT_WIDTH-1:0];
      if (y_s > SAT_HI)      sat_word_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (y_s < SAT_LO) sat_word_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   end

   // Result FIFO; a full FIFO still accepts a push when a pop happens the same cycle
   logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]        level_q;
   logic [7:0]           ovf_q;
   state_t               state_q, state_d;
   logic                 pop_c, push_c, drop_c;

   assign pop_c  = (state_q == IDLE) && (level_q != '0);
   assign push_c = tap_c && ((level_q != LW'(FIFO_DEPTH)) || pop_c);
   assign drop_c = tap_c && !push_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_q + LW'(push_c) - LW'(pop_c);
         if (drop_c && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= sat_word_c;
   end

   // UART transmitter
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [OUT_WIDTH-1:0] word_q, word_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic [7:0]           cur_byte_c;
   logic                 baud_wrap_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         baud_q     <= '0;
         word_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         baud_q     <= baud_d;
         word_q     <= word_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      bit_idx_d   = bit_idx_q;
      baud_d      = baud_q;
      word_d      = word_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      baud_wrap_c = (baud_q == BAUD_LAST);

      case (byte_idx_q)
         2'd0:    cur_byte_c = SYNC_BYTE;
         2'd1:    cur_byte_c = word_q[15:8];
         default: cur_byte_c = word_q[7:0];
      endcase

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (pop_c) begin
               state_d    = START;
               word_d     = mem_q[rd_ptr_q];
               byte_idx_d = 2'd0;
               baud_d     = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
            end
         end
         START: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap_c) begin
               baud_d    = '0;
               state_d   = DATA;
               bit_idx_d = 3'd0;
               tx_d      = cur_byte_c[0];
            end
         end
         DATA: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap_c) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = cur_byte_c[bit_idx_q + 3'd1];
               end
            end
         end
         default: begin
            baud_d = baud_q + BW'(1);
            if (baud_wrap_c) begin
               baud_d = '0;
               if (byte_idx_q < 2'd2) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
      endcase
   end

   assign tx           = tx_q;
   assign busy         = busy_q;
   assign fifo_level   = level_q;
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ecg_result_uart_tx.sv
// Randomized self-checking bench for ecg_result_uart_tx: a UART line decoder
// collects bytes, compared against frames predicted from the saturation/FIFO rules.
module tb_ecg_result_uart_tx;

   localparam int IW  = 38;
   localparam int L   = 9;
   localparam int D   = 4;
   localparam int CPB = 4;
   localparam int FRAME = 30 * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_valid;
   logic [IW-1:0] y_in;
   logic          tx, busy;
   logic [2:0]    fifo_level;
   logic [7:0]    overflow_cnt;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int ovf_model = 0;
   int meas_tx_fall, meas_busy_fall;
   int gap_q[$];

   ecg_result_uart_tx #(
      .IN_WIDTH(IW), .OUT_WIDTH(16), .LATENCY(L), .FIFO_DEPTH(D), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .y_in(y_in),
      .tx(tx), .busy(busy), .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input longint v);
      if (v > 32767)  return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      return 16'(v);
   endfunction

   function automatic longint rand_y();
      longint big;
      big = (longint'($urandom) << 4) + 32768;
      case ($urandom_range(0, 3))
         0: return longint'($urandom_range(0, 65535)) - 32768;
         1: return big;
         2: return -big;
         default: begin
            case ($urandom_range(0, 5))
               0: return 32767;
               1: return 32768;
               2: return -32768;
               3: return -32769;
               4: return -1;
               default: return 0;
            endcase
         end
      endcase
   endfunction

   // Line decoder: samples mid-bit, discards bytes that overlap reset or break framing
   initial begin
      logic [7:0] b;
      bit bad;
      forever begin
         @(negedge tx);
         if (rst) continue;
         bad = 1'b0;
         @(negedge clk);
         repeat (CPB / 2) @(negedge clk);
         if (tx !== 1'b0 || rst) bad = 1'b1;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
            if (rst) bad = 1'b1;
         end
         repeat (CPB) @(negedge clk);
         if (tx !== 1'b1 || rst) bad = 1'b1;
         if (!bad) rx_q.push_back(b);
      end
   end

   task automatic drive_burst(input longint v[$]);
      int n = v.size();
      for (int i = 0; i < n + L; i++) begin
         sample_valid = (i < n);
         if (i >= L && (i - L) < n) y_in = IW'(v[i - L]);
         else                       y_in = IW'({$urandom, $urandom});
         @(negedge clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic measure(input int ncyc);
      bit prev_busy = 1'b0;
      int fall_k = -1;
      meas_tx_fall = -1;
      meas_busy_fall = -1;
      gap_q.delete();
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (meas_tx_fall < 0 && tx == 1'b0) meas_tx_fall = k;
         if (prev_busy && !busy) begin
            if (meas_busy_fall < 0) meas_busy_fall = k;
            fall_k = k;
         end
         if (!prev_busy && busy && fall_k >= 0) gap_q.push_back(k - fall_k);
         prev_busy = busy;
      end
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int t = 0;
      while (quiet < 4 && t < 3000) begin
         @(negedge clk);
         t++;
         if (!busy && fifo_level == 0 && tx) quiet++;
         else quiet = 0;
      end
      if (quiet < 4) check("idle_timeout", t, 0);
   endtask

   task automatic compare_frames();
      int n;
      check("byte_count", rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   // Burst on consecutive cycles from an idle, empty state: the first word is
   // popped immediately, the next D are queued, the rest are dropped.
   task automatic run_burst(input longint v[$], input bit meas);
      int n = v.size();
      int kept = (n < D + 1) ? n : D + 1;
      logic [15:0] s;
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < kept; i++) begin
         s = sat16(v[i]);
         exp_q.push_back(8'hA5);
         exp_q.push_back(s[15:8]);
         exp_q.push_back(s[7:0]);
      end
      ovf_model = ovf_model + (n - kept);
      if (ovf_model > 255) ovf_model = 255;
      if (meas) begin
         fork
            drive_burst(v);
            measure(L + n * (FRAME + 1) + 20);
         join
      end else begin
         drive_burst(v);
         @(negedge clk);
         check("fifo_level", fifo_level, kept - 1);
      end
      wait_idle();
      check("overflow_cnt", overflow_cnt, ovf_model);
      compare_frames();
   endtask

   initial begin
      longint vq[$];
      rst = 1'b1;
      sample_valid = 1'b0;
      y_in = '0;
      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_level", fifo_level, 0);
      check("rst_ovf", overflow_cnt, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single sample: start bit and busy-fall timing
      vq = {longint'(16'h1234)};
      run_burst(vq, 1'b1);
      check("tx_fall_cycle", meas_tx_fall, L + 2);
      check("busy_fall_cycle", meas_busy_fall, L + 2 + FRAME);

      // Saturation cases queued back-to-back: one idle cycle between frames
      vq = {longint'(40000), longint'(-40000), longint'(-1)};
      run_burst(vq, 1'b1);
      check("gap_count", gap_q.size(), 2);
      foreach (gap_q[i]) check($sformatf("gap%0d", i), gap_q[i], 1);

      // Overflow: 10 consecutive valids into a depth-4 FIFO
      vq.delete();
      for (int i = 0; i < 10; i++) vq.push_back(longint'(i * 1000 - 3000));
      run_burst(vq, 1'b0);

      // Reset mid-frame with queued data and an in-flight valid
      vq.delete();
      for (int i = 0; i < 8; i++) vq.push_back(rand_y());
      drive_burst(vq);
      repeat (40) @(negedge clk);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_level", fifo_level, 0);
      check("midrst_ovf", overflow_cnt, 0);
      repeat (2 * CPB) @(negedge clk);
      rst = 1'b0;
      ovf_model = 0;
      rx_q.delete();
      repeat (400) @(negedge clk);
      check("post_rst_bytes", rx_q.size(), 0);
      check("post_rst_ovf", overflow_cnt, 0);
      check("post_rst_level", fifo_level, 0);

      // Randomized bursts
      for (int r = 0; r < 12; r++) begin
         vq.delete();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++) vq.push_back(rand_y());
         run_burst(vq, 1'b0);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // Drop counter saturation: three long bursts behind a full FIFO
      for (int r = 0; r < 3; r++) begin
         vq.delete();
         for (int i = 0; i < 110; i++) vq.push_back(rand_y());
         run_burst(vq, 1'b0);
      end
      check("ovf_saturated", overflow_cnt, 255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
